// File: rtl/lz4_pkg.sv
// ---------------------------------------------------------------------------
// lz4_pkg
// Shared definitions for the LZ4 output packer: FSM state encoding, word
// geometry constants and the byte-count to keep-mask helper.
// No ports (package).
// ---------------------------------------------------------------------------
package lz4_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_FILL      = 2'd1,
        ST_FLUSH     = 2'd2,
        ST_LAST_WAIT = 2'd3
    } pack_state_t;

    localparam int         BYTES_PER_WORD = 4;
    localparam logic [3:0] KEEP_FULL      = 4'b1111;

    // Leading-ones mask: lane 0 ([31:24]) is keep bit 3.
    function automatic logic [3:0] keep_mask(input logic [2:0] cnt);
        logic [3:0] mask;
        case (cnt)
            3'd0:    mask = 4'b0000;
            3'd1:    mask = 4'b1000;
            3'd2:    mask = 4'b1100;
            3'd3:    mask = 4'b1110;
            default: mask = KEEP_FULL;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/lz4_pack_acc.sv
// ---------------------------------------------------------------------------
// lz4_pack_acc
// Four-lane byte accumulator. A clear empties it in the same cycle as a new
// dword or byte is written, so the packer never loses a cycle on a move.
// Lanes above acc_cnt are always zero.
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   clear        discard current contents (word moved to output)
//   load_dword   write dword_in as a full word
//   load_byte    write byte_in into the next free lane
//   dword_in     source dword, first byte in [31:24]
//   byte_in      source byte
//   acc          accumulated word, lane 0 = [31:24]
//   acc_cnt      number of valid lanes, 0..4
// ---------------------------------------------------------------------------
module lz4_pack_acc
    import lz4_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        load_dword,
    input  logic        load_byte,
    input  logic [31:0] dword_in,
    input  logic [7:0]  byte_in,
    output logic [31:0] acc,
    output logic [2:0]  acc_cnt
);

    logic [31:0] acc_d;
    logic [2:0]  cnt_d;
    logic [2:0]  eff_cnt;
    logic [1:0]  lane_rev;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        eff_cnt  = clear ? 3'd0 : acc_cnt;
        lane_rev = 2'd3 - eff_cnt[1:0];
        acc_d    = clear ? 32'd0 : acc;
        cnt_d    = eff_cnt;
        if (load_dword) begin
            acc_d = dword_in;
            cnt_d = 3'(BYTES_PER_WORD);
        end else if (load_byte) begin
            acc_d[{lane_rev, 3'b000} +: 8] = byte_in;
            cnt_d = eff_cnt + 3'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc     <= '0;
            acc_cnt <= '0;
        end else begin
            acc     <= acc_d;
            acc_cnt <= cnt_d;
        end
    end

endmodule

// File: rtl/lz4_out_packer.sv
// ---------------------------------------------------------------------------
// lz4_out_packer
// Drains the LZ4 byte/dword shifter FIFO and repacks its byte stream into
// 32-bit words on a valid/ready bus. On end of stream (sticky flush) the
// final partial word goes out with a leading-ones keep mask and m_last.
//
// Optional feature: define LZ4_PACK_BYTE_CNT_EN to add byte_total, the sum
// of popcount(m_keep) over accepted words in the current stream.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   src_dout/src_byte_count/src_empty  source FIFO head and status
//   src_rd_en, src_byte_dwordN    pop strobe; 1 = byte, 0 = dword
//   flush                         end-of-stream pulse
//   m_data/m_keep/m_valid/m_last  packed output word, m_ready accepts
//   word_count                    words accepted in current stream
//   byte_total (optional)         bytes accepted in current stream
//   busy                          flush pending or data held
// ---------------------------------------------------------------------------
module lz4_out_packer
    import lz4_pkg::*;
#(
    parameter int WORD_CNT_W = 16,
    parameter int SRC_CNT_W  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           src_dout,
    input  logic [SRC_CNT_W-1:0]  src_byte_count,
    input  logic                  src_empty,
    output logic                  src_rd_en,
    output logic                  src_byte_dwordN,
    input  logic                  flush,
    output logic [31:0]           m_data,
    output logic [3:0]            m_keep,
    output logic                  m_valid,
    output logic                  m_last,
    input  logic                  m_ready,
    output logic [WORD_CNT_W-1:0] word_count,
`ifdef LZ4_PACK_BYTE_CNT_EN
    output logic [WORD_CNT_W+1:0] byte_total,
`endif
    output logic                  busy
);

    pack_state_t state_q, state_d;
    logic [31:0] acc;
    logic [2:0]  acc_cnt;
    logic        flush_pending;
    logic        out_free, in_flush, move, pop_dword, pop_byte;
    logic        emit_empty, set_last, hs, last_hs;
    logic [2:0]  eff_cnt;

    lz4_pack_acc u_acc (
        .clk        (clk),
        .rst        (rst),
        .clear      (move),
        .load_dword (pop_dword),
        .load_byte  (pop_byte),
        .dword_in   (src_dout),
        .byte_in    (src_dout[31:24]),
        .acc        (acc),
        .acc_cnt    (acc_cnt)
    );

    // Move and fetch decisions. A move frees the accumulator in the same
    // cycle, so a dword can refill it immediately (1 word/cycle). Pops are
    // suppressed while rst is high so no source data is consumed and lost.
    always_comb begin
        out_free  = !m_valid || m_ready;
        in_flush  = (state_q == ST_FLUSH);
        move      = ((acc_cnt == 3'(BYTES_PER_WORD)) || (in_flush && acc_cnt != 3'd0))
                    && out_free;
        eff_cnt   = move ? 3'd0 : acc_cnt;
        pop_dword = !rst && !in_flush && !src_empty && (eff_cnt == 3'd0)
                    && (src_byte_count >= SRC_CNT_W'(BYTES_PER_WORD));
        pop_byte  = !rst && !in_flush && !src_empty && !pop_dword
                    && (eff_cnt < 3'(BYTES_PER_WORD));
        hs        = m_valid && m_ready;
        last_hs   = hs && m_last;
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (pop_dword || pop_byte)          state_d = ST_FILL;
                else if (flush_pending && src_empty) state_d = ST_FLUSH;
            end
            ST_FILL: begin
                if (flush_pending && src_empty) state_d = ST_FLUSH;
            end
            // Only a partial word stalled behind a busy output waits here.
            ST_FLUSH: begin
                if (acc_cnt == 3'd0 || out_free) state_d = ST_LAST_WAIT;
            end
            ST_LAST_WAIT: begin
                if (last_hs) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM: outputs. With nothing in the accumulator, a held unsent word
    // becomes the last word (m_last rises on it); otherwise an empty
    // terminator word is emitted.
    always_comb begin
        emit_empty      = in_flush && (acc_cnt == 3'd0) && out_free;
        set_last        = in_flush && (acc_cnt == 3'd0) && m_valid && !m_ready;
        src_rd_en       = pop_dword || pop_byte;
        src_byte_dwordN = pop_byte;
        busy            = flush_pending || (acc_cnt != 3'd0) || m_valid;
    end

    // Output register
    always_ff @(posedge clk) begin
        if (rst) begin
            m_data  <= '0;
            m_keep  <= '0;
            m_last  <= 1'b0;
            m_valid <= 1'b0;
        end else if (move) begin
            m_data  <= acc;
            m_keep  <= keep_mask(acc_cnt);
            m_last  <= in_flush;
            m_valid <= 1'b1;
        end else if (emit_empty) begin
            m_data  <= '0;
            m_keep  <= '0;
            m_last  <= 1'b1;
            m_valid <= 1'b1;
        end else if (set_last) begin
            m_last  <= 1'b1;
        end else if (hs) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
        end
    end

    // Sticky flush and per-stream counters; the last handshake ends the stream.
    always_ff @(posedge clk) begin
        if (rst) begin
            flush_pending <= 1'b0;
            word_count    <= '0;
        end else begin
            if (last_hs)    flush_pending <= 1'b0;
            else if (flush) flush_pending <= 1'b1;
            if (last_hs)    word_count <= '0;
            else if (hs)    word_count <= word_count + 1'b1;
        end
    end

`ifdef LZ4_PACK_BYTE_CNT_EN
    always_ff @(posedge clk) begin
        if (rst || last_hs) byte_total <= '0;
        else if (hs)        byte_total <= byte_total + (WORD_CNT_W+2)'($countones(m_keep));
    end
`endif

endmodule

// File: tb/tb_lz4_out_packer.sv
// ---------------------------------------------------------------------------
// tb_lz4_out_packer
// Directed bench: a queue-based source FIFO, a stream-level word model
// (bytes grouped by four, tail packed on flush) and a per-cycle compare
// process on the output handshake, plus literal expectations per scenario.
// ---------------------------------------------------------------------------
module tb_lz4_out_packer;

    localparam int WCW = 16;
    localparam int SCW = 6;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } word_t;

    logic           clk = 1'b0;
    logic           rst;
    logic [31:0]    src_dout;
    logic [SCW-1:0] src_byte_count;
    logic           src_empty;
    logic           src_rd_en;
    logic           src_byte_dwordN;
    logic           flush;
    logic [31:0]    m_data;
    logic [3:0]     m_keep;
    logic           m_valid;
    logic           m_last;
    logic           m_ready;
    logic [WCW-1:0] word_count;
    logic           busy;
`ifdef LZ4_PACK_BYTE_CNT_EN
    logic [WCW+1:0] byte_total;
`endif

    lz4_out_packer #(.WORD_CNT_W(WCW), .SRC_CNT_W(SCW)) dut (
        .clk             (clk),
        .rst             (rst),
        .src_dout        (src_dout),
        .src_byte_count  (src_byte_count),
        .src_empty       (src_empty),
        .src_rd_en       (src_rd_en),
        .src_byte_dwordN (src_byte_dwordN),
        .flush           (flush),
        .m_data          (m_data),
        .m_keep          (m_keep),
        .m_valid         (m_valid),
        .m_last          (m_last),
        .m_ready         (m_ready),
        .word_count      (word_count),
`ifdef LZ4_PACK_BYTE_CNT_EN
        .byte_total      (byte_total),
`endif
        .busy            (busy)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          popped_bytes = 0;
    int          stream_total = 0;
    logic [7:0]  src_q[$];
    logic [7:0]  stream_q[$];
    word_t       exp_q[$];
    word_t       obs_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // All stimulus changes land 2 time units after a rising edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // ---------------- stream model ----------------
    task automatic send_byte(input logic [7:0] b);
        src_q.push_back(b);
        stream_q.push_back(b);
        stream_total++;
        if (stream_q.size() == 4) begin
            exp_q.push_back({stream_q[0], stream_q[1], stream_q[2], stream_q[3], 4'hF, 1'b0});
            stream_q.delete();
        end
    endtask

    task automatic send_bytes(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) send_byte(first + 8'(i));
    endtask

    task automatic model_flush();
        logic [31:0] d;
        logic [3:0]  k;
        int          r;
        r = stream_q.size();
        d = '0;
        if (r > 0) begin
            for (int i = 0; i < r; i++) d[31-8*i -: 8] = stream_q[i];
            k = 4'(4'hF << (4 - r));
            exp_q.push_back({d, k, 1'b1});
        end else if (stream_total == 0) begin
            exp_q.push_back({32'd0, 4'b0000, 1'b1});
        end
        stream_q.delete();
        stream_total = 0;
    endtask

    // ---------------- source FIFO ----------------
    // Pop request is taken at the falling edge: inputs only move just after
    // a rising edge, so this is the value the DUT sees at the next edge.
    initial begin : src_fifo
        logic        rd, bdw;
        logic [31:0] d;
        int          n;
        src_dout = '0; src_byte_count = '0; src_empty = 1'b1;
        forever begin
            @(negedge clk);
            rd  = src_rd_en;
            bdw = src_byte_dwordN;
            @(posedge clk);
            #1;
            if (rd) begin
                n = bdw ? 1 : 4;
                check("pop_avail", src_q.size() >= n, 1'b1);
                if (src_q.size() >= n) begin
                    for (int i = 0; i < n; i++) void'(src_q.pop_front());
                    popped_bytes += n;
                end
            end
            #2;
            d = '0;
            for (int i = 0; i < 4; i++) if (i < src_q.size()) d[31-8*i -: 8] = src_q[i];
            src_dout       = d;
            src_byte_count = SCW'((src_q.size() > 63) ? 63 : src_q.size());
            src_empty      = (src_q.size() == 0);
        end
    end

    // ---------------- compare process ----------------
    initial begin : compare
        logic  prev_stall;
        word_t held, e;
        prev_stall = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("hold_data", m_data, held.data);
                    check("hold_keep", m_keep, held.keep);
                end
                if (src_rd_en) check("rd_while_empty", src_empty, 1'b0);
                if (src_rd_en && !src_byte_dwordN)
                    check("dword_count", src_byte_count >= 4, 1'b1);
                if (m_valid && m_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_word", exp_q.size(), 1);
                    end else begin
                        e = exp_q.pop_front();
                        check("word_data", m_data, e.data);
                        check("word_keep", m_keep, e.keep);
                        check("word_last", m_last, e.last);
                    end
                    obs_q.push_back({m_data, m_keep, m_last});
                end
                prev_stall = m_valid && !m_ready;
                held = {m_data, m_keep, m_last};
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        src_q.delete(); exp_q.delete(); obs_q.delete(); stream_q.delete();
        stream_total = 0;
        step();
        rst = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 200; i++) begin
            if (exp_q.size() == 0 && !busy) break;
            @(negedge clk);
        end
        check(name, exp_q.size(), 0);
    endtask

    task automatic pulse_flush(input int cycles);
        step();
        flush = 1'b1;
        repeat (cycles) step();
        flush = 1'b0;
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- directed scenarios ----------------
    initial begin : main
        rst = 1'b1; flush = 1'b0; m_ready = 1'b0;
        step(); step();
        rst = 1'b0;
        @(negedge clk);
        check("rst_m_valid", m_valid, 1'b0);
        check("rst_m_data", m_data, 32'h0);
        check("rst_m_keep", m_keep, 4'h0);
        check("rst_m_last", m_last, 1'b0);
        check("rst_word_count", word_count, 0);
        check("rst_busy", busy, 1'b0);
        check("rst_rd_en", src_rd_en, 1'b0);

        // Two dwords, back to back at one word per cycle.
        step();
        m_ready = 1'b1;
        send_bytes(8'h11, 0);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        send_byte(8'h55); send_byte(8'h66); send_byte(8'h77); send_byte(8'h88);
        @(negedge clk);
        check("t1_pop0_rd", src_rd_en, 1'b1);
        check("t1_pop0_dword", src_byte_dwordN, 1'b0);
        @(negedge clk);
        check("t1_pop1_rd", src_rd_en, 1'b1);
        check("t1_pop1_dword", src_byte_dwordN, 1'b0);
        @(negedge clk);
        check("t1_valid_a", m_valid, 1'b1);
        @(negedge clk);
        check("t1_valid_b", m_valid, 1'b1);
        drain("t1_drain");
        check("t1_words", obs_q.size(), 2);
        if (obs_q.size() == 2) begin
            check("t1_w0", obs_q[0].data, 32'h11223344);
            check("t1_w1", obs_q[1].data, 32'h55667788);
            check("t1_k1", obs_q[1].keep, 4'b1111);
        end
        check("t1_word_count", word_count, 2);
`ifdef LZ4_PACK_BYTE_CNT_EN
        check("t1_byte_total", byte_total, 8);
`endif

        // Three bytes then flush: one partial last word.
        do_reset();
        m_ready = 1'b1;
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
        model_flush();
        pulse_flush(1);
        drain("t2_drain");
        check("t2_words", obs_q.size(), 1);
        if (obs_q.size() == 1) begin
            check("t2_data", obs_q[0].data, 32'hAABBCC00);
            check("t2_keep", obs_q[0].keep, 4'b1110);
            check("t2_last", obs_q[0].last, 1'b1);
        end
        check("t2_busy", busy, 1'b0);
        check("t2_word_count", word_count, 0);
`ifdef LZ4_PACK_BYTE_CNT_EN
        check("t2_byte_total", byte_total, 0);
`endif

        // Backpressure: 12 bytes, output stalled; only two words fit.
        do_reset();
        m_ready = 1'b0;
        popped_bytes = 0;
        send_bytes(8'h20, 12);
        repeat (6) @(negedge clk);
        check("t3_popped", popped_bytes, 8);
        check("t3_rd_idle", src_rd_en, 1'b0);
        check("t3_valid", m_valid, 1'b1);
        check("t3_head", m_data, 32'h20212223);
        step();
        m_ready = 1'b1;
        drain("t3_drain");
        check("t3_words", obs_q.size(), 3);
        if (obs_q.size() == 3) check("t3_w2", obs_q[2].data, 32'h28292A2B);
        check("t3_word_count", word_count, 3);

        // Flush with nothing held (flush held two cycles; second is ignored).
        do_reset();
        m_ready = 1'b1;
        model_flush();
        pulse_flush(2);
        drain("t4_drain");
        check("t4_words", obs_q.size(), 1);
        if (obs_q.size() == 1) begin
            check("t4_data", obs_q[0].data, 32'h0);
            check("t4_keep", obs_q[0].keep, 4'b0000);
            check("t4_last", obs_q[0].last, 1'b1);
        end
        check("t4_busy", busy, 1'b0);

        // Six bytes then flush: full word plus two-byte tail.
        do_reset();
        m_ready = 1'b1;
        send_bytes(8'h01, 6);
        model_flush();
        pulse_flush(1);
        drain("t5_drain");
        check("t5_words", obs_q.size(), 2);
        if (obs_q.size() == 2) begin
            check("t5_w0", obs_q[0].data, 32'h01020304);
            check("t5_k0", obs_q[0].keep, 4'b1111);
            check("t5_l0", obs_q[0].last, 1'b0);
            check("t5_w1", obs_q[1].data, 32'h05060000);
            check("t5_k1", obs_q[1].keep, 4'b1100);
            check("t5_l1", obs_q[1].last, 1'b1);
        end
        check("t5_word_count", word_count, 0);

        // Reset while a word is held and two bytes sit in the accumulator.
        do_reset();
        m_ready = 1'b0;
        popped_bytes = 0;
        send_bytes(8'h01, 6);
        repeat (5) @(negedge clk);
        check("t6_valid_pre", m_valid, 1'b1);
        check("t6_popped_pre", popped_bytes, 6);
        check("t6_busy_pre", busy, 1'b1);
        step();
        do_reset();
        @(negedge clk);
        check("t6_valid", m_valid, 1'b0);
        check("t6_word_count", word_count, 0);
        check("t6_rd_en", src_rd_en, 1'b0);
        check("t6_busy", busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
